// File: rtl/result_serializer.sv
// result_serializer
//   Turns a parallel bundle of six 32-bit arithmetic results into a word
//   stream, optionally followed by an XOR checksum word. Two bundles can be
//   held at once: the active bundle (the one being streamed) and one pending
//   bundle waiting behind it. Bundles stream back to back with no idle cycle.
//
// Handshake rule (both sides): a transfer happens at a rising clk edge when
//   valid and ready are both high. A producer holding valid high keeps its
//   data stable until that edge; in_ready never depends on in_valid.
//
// Ports
//   clk                 sole clock, rising edge
//   rst_n               asynchronous active-low reset
//   in_valid/in_ready   bundle handshake; output1..output6 sampled on acceptance
//   output1..output6    upstream results (inputs to this block)
//   out_valid/out_ready stream word handshake
//   out_data            stream word, 0 while out_valid is low
//   out_idx             0..5 = output1..output6, 6 = checksum
//   out_last            high on the final word of a bundle
module result_serializer #(
    parameter int CHECKSUM_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] output1,
    input  logic [31:0] output2,
    input  logic [31:0] output3,
    input  logic [31:0] output4,
    input  logic [31:0] output5,
    input  logic [31:0] output6,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [2:0]  out_idx,
    output logic        out_last
);

    // Index of the final word of a bundle (L - 1).
    localparam logic [2:0] LAST_IDX = (CHECKSUM_EN != 0) ? 3'd6 : 3'd5;

    logic [31:0] act_w  [0:6];
    logic        act_valid;
    logic [2:0]  idx;
    logic [31:0] pend_w [0:6];
    logic        pend_valid;

    logic [31:0] in_w   [0:6];
    logic        accept;
    logic        out_fire;
    logic        last_fire;
    logic        load_act;
    logic        load_pend;

    // Incoming bundle with its checksum already folded in as word 6.
    always_comb begin
        in_w[0] = output1;
        in_w[1] = output2;
        in_w[2] = output3;
        in_w[3] = output4;
        in_w[4] = output5;
        in_w[5] = output6;
        in_w[6] = (CHECKSUM_EN != 0)
                ? (output1 ^ output2 ^ output3 ^ output4 ^ output5 ^ output6)
                : 32'd0;
    end

    assign in_ready  = !pend_valid;
    assign accept    = in_valid && in_ready;
    assign out_fire  = act_valid && out_ready;
    assign last_fire = out_fire && (idx == LAST_IDX);

    // A new bundle goes straight to active when active is empty or is
    // retiring this very edge (accept already implies pending is empty).
    assign load_act  = accept && (!act_valid || last_fire);
    assign load_pend = accept && !load_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_valid  <= 1'b0;
            pend_valid <= 1'b0;
            idx        <= 3'd0;
            for (int i = 0; i < 7; i++) begin
                act_w[i]  <= 32'd0;
                pend_w[i] <= 32'd0;
            end
        end else begin
            if (out_fire) begin
                idx <= last_fire ? 3'd0 : idx + 3'd1;
            end

            if (last_fire) begin
                if (pend_valid) begin
                    // Pending bundle follows immediately; active stays valid.
                    act_w      <= pend_w;
                    pend_valid <= 1'b0;
                end else if (load_act) begin
                    act_w <= in_w;
                end else begin
                    act_valid <= 1'b0;
                end
            end else if (load_act) begin
                act_w     <= in_w;
                act_valid <= 1'b1;
            end

            if (load_pend) begin
                pend_w     <= in_w;
                pend_valid <= 1'b1;
            end
        end
    end

    assign out_valid = act_valid;
    assign out_data  = act_valid ? act_w[idx] : 32'd0;
    assign out_idx   = idx;
    assign out_last  = act_valid && (idx == LAST_IDX);

endmodule

// File: doc/result_serializer.md
RESULT_SERIALIZER -- requirements
Module: result_serializer

Interface
REQ-001 SHALL have parameter CHECKSUM_EN, default 1, which when 1 appends an XOR checksum word after the six results.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  result bundle valid.
REQ-005 SHALL have port in_ready  output  1  bundle accepted when in_valid and in_ready are both high at a clk edge.
REQ-006 SHALL have ports output1..output6  input  32 each  upstream arithmetic results, sampled only on acceptance.
REQ-007 SHALL have port out_valid  output  1  stream word valid.
REQ-008 SHALL have port out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.
REQ-009 SHALL have port out_data  output  32  stream word.
REQ-010 SHALL have port out_idx  output  3  word index: 0..5 = output1..output6; 6 = checksum.
REQ-011 SHALL have port out_last  output  1  high on the final word of a bundle.

Function
REQ-012 SHALL hold an active bundle register (six words, checksum, valid flag, 3-bit index counter) and one pending bundle register (six words, checksum, valid flag).
REQ-013 SHALL drive in_ready = !pending_valid, combinationally from register state only, with no path from in_valid.
REQ-014 SHALL compute the checksum at acceptance as output1^output2^...^output6 (32-bit bitwise XOR).
REQ-015 SHALL define L = 6 + CHECKSUM_EN as the words per bundle.
REQ-016 On acceptance: SHALL load the active register if active is empty, or if active's last word handshakes this same cycle and pending is empty; otherwise SHALL load the pending register.
REQ-017 SHALL set out_valid = active_valid, and out_data/out_idx = the active word selected by the index counter; out_last = (index == L-1) && out_valid.
REQ-018 Latency SHALL be: a bundle accepted at edge N into an empty active register presents word 0 with out_valid=1 from edge N onward (visible in cycle N+1).
REQ-019 On each out handshake with index < L-1, the index SHALL increment by 1.
REQ-020 On handshake of the last word, the index SHALL return to 0; if pending is valid, pending SHALL move to active at that edge and pending_valid SHALL clear. Else, if a same-cycle acceptance occurs, the new bundle SHALL load active. Else active_valid SHALL clear.
REQ-021 Back-to-back bundles SHALL stream with no idle cycle between word L-1 of one bundle and word 0 of the next while out_ready stays high.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL remain stable, and out_valid SHALL NOT drop.
REQ-023 With both registers full, in_ready SHALL be 0 and inputs SHALL be ignored; at most 2 bundles SHALL be held at any time.
REQ-024 Bundle order SHALL be preserved; no word SHALL be duplicated or dropped.
REQ-025 out_data SHALL be 0 when out_valid=0.

Reset
REQ-026 While rst_n=0, the block SHALL be asynchronously cleared: active_valid=0, pending_valid=0, index=0, all stored words=0.
REQ-027 Immediately after reset: out_valid=0, out_data=0, out_idx=0, out_last=0, in_ready=1.
REQ-028 Reset asserted mid-bundle SHALL discard all buffered data, and no partial bundle SHALL be emitted after release.
REQ-029 The first acceptance SHALL be possible at the first clk edge after rst_n rises.

Verification
REQ-030 Single bundle: output1..6 = 1,2,3,4,5,6, out_ready held 1 -> out_data 1,2,3,4,5,6,7 on consecutive cycles with idx 0..6, out_last only at idx 6 (checksum 1^2^3^4^5^6 = 7).
REQ-031 Backpressure: out_ready=0 for 5 cycles at idx 2 -> out_data=3 and idx=2 held stable with out_valid=1; the stream resumes at 3 once out_ready=1.
REQ-032 Back-to-back: bundles A (all words 0xA) then B (all words 0xB) offered continuously with out_ready=1 -> 14 words with no gap; checksums 0x0 and 0x0; third bundle sees in_ready=0 until A's last word handshakes.
REQ-033 Full buffer: out_ready=0, offer 3 bundles -> first two accepted, in_ready=0 thereafter, third accepted the cycle after A's idx-6 handshake.
REQ-034 Reset mid-stream: assert rst_n=0 at idx 3 of a bundle -> outputs immediately 0, in_ready=1; after release, no residual words appear.
REQ-035 CHECKSUM_EN=0: bundle 0xFFFFFFFF x6 -> six words, out_last at idx 5, idx 6 never appears.
